// File: rtl/regfile_write_arbiter_if.sv
// regfile_write_arbiter_if: requester handshakes, clear control and regfile write port
interface regfile_write_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
);
    logic                  req0_valid;
    logic [ADDR_WIDTH-1:0] req0_addr;
    logic [DATA_WIDTH-1:0] req0_data;
    logic                  req0_ready;
    logic                  req1_valid;
    logic [ADDR_WIDTH-1:0] req1_addr;
    logic [DATA_WIDTH-1:0] req1_data;
    logic                  req1_ready;
    logic                  clear_start;
    logic                  clear_busy;
    logic [ADDR_WIDTH-1:0] writereg;
    logic [DATA_WIDTH-1:0] writedata;
    logic                  writeenable;
    logic                  grant_id;

    modport master (
        output req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data, clear_start,
        input  req0_ready, req1_ready, clear_busy, writereg, writedata, writeenable, grant_id
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data, clear_start,
        output req0_ready, req1_ready, clear_busy, writereg, writedata, writeenable, grant_id
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin sharing of the regfile write port plus a clear sweep
module regfile_write_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int NUM_REGS   = 8
) (
    input logic clk,
    input logic rst_n,
    regfile_write_arbiter_if.slave bus
);
    typedef enum logic {ARB, CLEAR} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_REG = ADDR_WIDTH'(NUM_REGS - 1);

    state_t                state, state_nxt;
    logic                  last, last_nxt;
    logic                  we_nxt, busy_nxt, gid_nxt;
    logic [ADDR_WIDTH-1:0] reg_nxt;
    logic [DATA_WIDTH-1:0] data_nxt;
    logic                  open;

    // clear_start beats any pending request in the same cycle
    assign open = (state == ARB) && !bus.clear_start;
    assign bus.req0_ready = open && bus.req0_valid && (!bus.req1_valid || last);
    assign bus.req1_ready = open && bus.req1_valid && (!bus.req0_valid || !last);

    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        we_nxt    = 1'b0;
        busy_nxt  = bus.clear_busy;
        gid_nxt   = bus.grant_id;
        reg_nxt   = bus.writereg;
        data_nxt  = bus.writedata;
        if (state == ARB) begin
            if (bus.clear_start) begin
                state_nxt = CLEAR;
                we_nxt    = 1'b1;
                busy_nxt  = 1'b1;
                gid_nxt   = 1'b0;
                reg_nxt   = '0;
                data_nxt  = '0;
            end else if (bus.req0_ready || bus.req1_ready) begin
                we_nxt   = 1'b1;
                gid_nxt  = bus.req1_ready;
                last_nxt = bus.req1_ready;
                reg_nxt  = bus.req1_ready ? bus.req1_addr : bus.req0_addr;
                data_nxt = bus.req1_ready ? bus.req1_data : bus.req0_data;
            end
        end else if (bus.writereg == LAST_REG) begin
            state_nxt = ARB;
            busy_nxt  = 1'b0;
        end else begin
            we_nxt  = 1'b1;
            reg_nxt = bus.writereg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ARB;
            last            <= 1'b1;
            bus.writeenable <= 1'b0;
            bus.clear_busy  <= 1'b0;
            bus.grant_id    <= 1'b0;
            bus.writereg    <= '0;
            bus.writedata   <= '0;
        end else begin
            state           <= state_nxt;
            last            <= last_nxt;
            bus.writeenable <= we_nxt;
            bus.clear_busy  <= busy_nxt;
            bus.grant_id    <= gid_nxt;
            bus.writereg    <= reg_nxt;
            bus.writedata   <= data_nxt;
        end
    end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed vector table plus reset/clear corner sequences
module tb_regfile_write_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] rf [8];

    regfile_write_arbiter_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) bus ();
    regfile_write_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .NUM_REGS(8)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // behavioural register file behind the write port
    always @(posedge clk) if (bus.writeenable) rf[bus.writereg] <= bus.writedata;

    typedef struct {
        logic       v0; logic [2:0] a0; logic [7:0] d0;
        logic       v1; logic [2:0] a1; logic [7:0] d1;
        logic       cs;
        logic       r0, r1, we;
        logic [2:0] rg; logic [7:0] dat;
        logic       gid, busy;
        logic       rf_en; logic [2:0] rf_a; logic [7:0] rf_v;
    } vec_t;

    vec_t t [26];

    function automatic vec_t mk(input logic v0, input logic [2:0] a0, input logic [7:0] d0,
                                input logic v1, input logic [2:0] a1, input logic [7:0] d1,
                                input logic cs, input logic r0, input logic r1, input logic we,
                                input logic [2:0] rg, input logic [7:0] dat, input logic gid,
                                input logic busy, input logic rf_en, input logic [2:0] rf_a,
                                input logic [7:0] rf_v);
        vec_t v;
        v.v0 = v0; v.a0 = a0; v.d0 = d0; v.v1 = v1; v.a1 = a1; v.d1 = d1; v.cs = cs;
        v.r0 = r0; v.r1 = r1; v.we = we; v.rg = rg; v.dat = dat; v.gid = gid; v.busy = busy;
        v.rf_en = rf_en; v.rf_a = rf_a; v.rf_v = rf_v;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v0, input logic [2:0] a0, input logic [7:0] d0,
                         input logic v1, input logic [2:0] a1, input logic [7:0] d1, input logic cs);
        bus.req0_valid = v0; bus.req0_addr = a0; bus.req0_data = d0;
        bus.req1_valid = v1; bus.req1_addr = a1; bus.req1_data = d1;
        bus.clear_start = cs;
    endtask

    task automatic chk_outs(input string tag, input logic we, input logic [2:0] rg,
                            input logic [7:0] dat, input logic gid, input logic busy);
        chk({tag, " we"}, 32'(bus.writeenable), 32'(we));
        chk({tag, " reg"}, 32'(bus.writereg), 32'(rg));
        chk({tag, " data"}, 32'(bus.writedata), 32'(dat));
        chk({tag, " gid"}, 32'(bus.grant_id), 32'(gid));
        chk({tag, " busy"}, 32'(bus.clear_busy), 32'(busy));
    endtask

    initial begin
        bit hit;
        //          v0 a0 d0     v1 a1 d1     cs r0 r1 we rg dat    g  b  rfe rfa rfv
        t[0]  = mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00);
        t[1]  = mk(1, 2, 8'd95, 0, 0, 8'h00, 0, 1, 0, 1, 2, 8'd95, 0, 0, 0, 0, 8'h00);
        t[2]  = mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 2, 8'd95, 0, 0, 1, 2, 8'd95);
        t[3]  = mk(0, 0, 8'h00, 1, 5, 8'd33, 0, 0, 1, 1, 5, 8'd33, 1, 0, 0, 0, 8'h00);
        t[4]  = mk(1, 1, 8'd28, 1, 4, 8'd6,  0, 1, 0, 1, 1, 8'd28, 0, 0, 1, 5, 8'd33);
        t[5]  = mk(0, 0, 8'h00, 1, 4, 8'd6,  0, 0, 1, 1, 4, 8'd6,  1, 0, 1, 1, 8'd28);
        t[6]  = mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 4, 8'd6,  1, 0, 1, 4, 8'd6);
        t[7]  = mk(1, 3, 8'h11, 1, 5, 8'h21, 0, 1, 0, 1, 3, 8'h11, 0, 0, 0, 0, 8'h00);
        t[8]  = mk(1, 3, 8'h12, 1, 5, 8'h21, 0, 0, 1, 1, 5, 8'h21, 1, 0, 1, 3, 8'h11);
        t[9]  = mk(1, 3, 8'h12, 1, 6, 8'h22, 0, 1, 0, 1, 3, 8'h12, 0, 0, 1, 5, 8'h21);
        t[10] = mk(1, 7, 8'h13, 1, 6, 8'h22, 0, 0, 1, 1, 6, 8'h22, 1, 0, 0, 0, 8'h00);
        t[11] = mk(1, 7, 8'h13, 1, 0, 8'h23, 0, 1, 0, 1, 7, 8'h13, 0, 0, 0, 0, 8'h00);
        t[12] = mk(1, 2, 8'h14, 1, 0, 8'h23, 0, 0, 1, 1, 0, 8'h23, 1, 0, 1, 7, 8'h13);
        t[13] = mk(1, 2, 8'hAA, 1, 2, 8'hBB, 0, 1, 0, 1, 2, 8'hAA, 0, 0, 1, 0, 8'h23);
        t[14] = mk(0, 0, 8'h00, 1, 2, 8'hBB, 0, 0, 1, 1, 2, 8'hBB, 1, 0, 1, 2, 8'hAA);
        t[15] = mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 2, 8'hBB, 1, 0, 1, 2, 8'hBB);
        t[16] = mk(0, 0, 8'h00, 1, 3, 8'h77, 1, 0, 0, 1, 0, 8'h00, 0, 1, 0, 0, 8'h00);
        t[17] = mk(0, 0, 8'h00, 1, 3, 8'h77, 0, 0, 0, 1, 1, 8'h00, 0, 1, 1, 0, 8'h00);
        t[18] = mk(0, 0, 8'h00, 1, 3, 8'h77, 1, 0, 0, 1, 2, 8'h00, 0, 1, 1, 1, 8'h00);
        t[19] = mk(0, 0, 8'h00, 1, 3, 8'h77, 0, 0, 0, 1, 3, 8'h00, 0, 1, 1, 2, 8'h00);
        t[20] = mk(0, 0, 8'h00, 1, 3, 8'h77, 0, 0, 0, 1, 4, 8'h00, 0, 1, 0, 0, 8'h00);
        t[21] = mk(0, 0, 8'h00, 1, 3, 8'h77, 0, 0, 0, 1, 5, 8'h00, 0, 1, 1, 4, 8'h00);
        t[22] = mk(0, 0, 8'h00, 1, 3, 8'h77, 0, 0, 0, 1, 6, 8'h00, 0, 1, 1, 5, 8'h00);
        t[23] = mk(0, 0, 8'h00, 1, 3, 8'h77, 0, 0, 0, 1, 7, 8'h00, 0, 1, 1, 6, 8'h00);
        t[24] = mk(0, 0, 8'h00, 1, 3, 8'h77, 0, 0, 0, 0, 7, 8'h00, 0, 0, 1, 7, 8'h00);
        t[25] = mk(0, 0, 8'h00, 1, 3, 8'h77, 0, 0, 1, 1, 3, 8'h77, 1, 0, 1, 2, 8'h00);

        drive(0, 0, 0, 0, 0, 0, 0);
        #12;
        chk_outs("reset", 0, 0, 8'h00, 0, 0);
        @(negedge clk) rst_n = 1'b1;

        foreach (t[i]) begin
            @(negedge clk);
            drive(t[i].v0, t[i].a0, t[i].d0, t[i].v1, t[i].a1, t[i].d1, t[i].cs);
            #1;
            chk($sformatf("v%0d ready0", i), 32'(bus.req0_ready), 32'(t[i].r0));
            chk($sformatf("v%0d ready1", i), 32'(bus.req1_ready), 32'(t[i].r1));
            @(posedge clk); #1;
            chk_outs($sformatf("v%0d", i), t[i].we, t[i].rg, t[i].dat, t[i].gid, t[i].busy);
            if (t[i].rf_en) chk($sformatf("v%0d rf[%0d]", i, t[i].rf_a), 32'(rf[t[i].rf_a]), 32'(t[i].rf_v));
        end

        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        chk("post-clear rf[3]", 32'(rf[3]), 32'h77);
        chk("post-clear rf[1]", 32'(rf[1]), 32'h00);

        // asynchronous reset mid-cycle while a write is visible
        @(negedge clk);
        drive(1, 6, 8'h5A, 0, 0, 0, 0);
        @(posedge clk); #3;
        chk("pre-rst we", 32'(bus.writeenable), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_outs("async rst", 0, 0, 8'h00, 0, 0);
        @(negedge clk);
        drive(1, 6, 8'h5A, 1, 1, 8'h3C, 0);
        rst_n = 1'b1;
        #1;
        chk("rst release ready0", 32'(bus.req0_ready), 32'd1);
        chk("rst release ready1", 32'(bus.req1_ready), 32'd0);
        @(posedge clk); #1;
        chk_outs("rst release", 1, 6, 8'h5A, 0, 0);

        // reset in the middle of a clear sweep
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        drive(0, 0, 0, 1, 4, 8'h99, 0);
        hit = 0;
        for (int k = 0; k < 20 && !hit; k++) begin
            if (bus.writereg == 3'd3 && bus.clear_busy) hit = 1;
            else @(negedge clk);
        end
        chk("reached clear reg 3", 32'(hit), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_outs("mid-clear rst", 0, 0, 8'h00, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("after mid-clear ready1", 32'(bus.req1_ready), 32'd1);
        @(posedge clk); #1;
        chk_outs("after mid-clear", 1, 4, 8'h99, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
